// File: rtl/btn_evt_arb_pkg.sv
// Shared definitions for the button event arbiter.
// FSM encodings and the released-button level.
package btn_evt_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } st_e;

  localparam logic BTN_REL = 1'b1;

endpackage

// File: rtl/btn_rr_pick.sv
// Combinational round-robin select: first pending bit
// after last_grant, wrapping modulo N_BTN.
module btn_rr_pick
  import btn_evt_arb_pkg::*;
#(
  parameter int N_BTN = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_BTN-1:0] pending,
  input  logic [IDX_W-1:0] last_grant,
  output logic             any,
  output logic [IDX_W-1:0] pick
);

  int j;

  always_comb begin
    any  = 1'b0;
    pick = '0;
    j    = 0;
    for (int k = 1; k <= N_BTN; k++) begin
      j = (int'(last_grant) + k) % N_BTN;
      if (!any && pending[j[IDX_W-1:0]]) begin
        any  = 1'b1;
        pick = j[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/btn_evt_arb.sv
// Button front end: tick-paced sampler, press latch and
// round-robin serialiser onto one valid/ready event port.
module btn_evt_arb
  import btn_evt_arb_pkg::*;
#(
  parameter int N_BTN    = 4,
  parameter int BIT_SIZE = 20,
  parameter int IDX_W    = 2
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic [N_BTN-1:0] i_bin,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_ovf
);

  logic [BIT_SIZE-1:0] cnt;
  logic                tick;
  logic [N_BTN-1:0]    s1;
  logic [N_BTN-1:0]    s2;
  logic [N_BTN-1:0]    press;
  logic [N_BTN-1:0]    pending;
  logic [N_BTN-1:0]    clr;
  logic [IDX_W-1:0]    last_grant;
  logic                any;
  logic [IDX_W-1:0]    pick;
  logic                load;
  st_e                 state;
  st_e                 nxt;

  assign tick = &cnt;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1 <= {N_BTN{BTN_REL}};
      s2 <= {N_BTN{BTN_REL}};
    end else if (tick) begin
      s1 <= i_bin;
      s2 <= s1;
    end
  end

  assign press = {N_BTN{tick}} & ~s1 & s2;

  btn_rr_pick #(
    .N_BTN(N_BTN),
    .IDX_W(IDX_W)
  ) u_pick (
    .pending   (pending),
    .last_grant(last_grant),
    .any       (any),
    .pick      (pick)
  );

  assign load = (state == ST_IDLE) & any;
  assign clr  = load ? (N_BTN'(1) << pick) : '0;

  // A new press on a bit being cleared re-arms it without overrun.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending <= '0;
      o_ovf   <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | press;
      o_ovf   <= |(press & pending & ~clr);
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_idx      <= '0;
      last_grant <= IDX_W'(N_BTN - 1);
    end else if (load) begin
      o_idx      <= pick;
      last_grant <= pick;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE:  if (any)     nxt = ST_VALID;
      ST_VALID: if (i_ready) nxt = ST_IDLE;
      default:               nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_valid = (state == ST_VALID);
  end

endmodule
